// File: rtl/eth_top_pkg.sv
// Shared AXI-Stream request/response types of the eth_top TX interface.
package eth_top_pkg;

  typedef struct packed {
    logic [63:0] tdata;
    logic        tlast;
    logic        tuser;
    logic        tvalid;
  } s_req_t;

  typedef struct packed {
    logic tready;
  } s_rsp_t;

endpackage

// File: rtl/eth_tx_arb_pkg.sv
// Types and defaults for the frame-granular TX arbiter.
package eth_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  // 190 beats x 8 bytes covers a 1518-byte frame.
  localparam int unsigned MAX_BEATS_DEFAULT = 32'd190;

endpackage

// File: rtl/eth_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr_i.
module eth_rr_pick #(
  parameter int unsigned NumPorts = 4,
  parameter int unsigned IdxW     = 2
) (
  input  logic [NumPorts-1:0] valid_i,
  input  logic [IdxW-1:0]     ptr_i,
  output logic [NumPorts-1:0] onehot_o,
  output logic [IdxW-1:0]     idx_o,
  output logic                any_o
);

  // Scan from farthest to nearest so the nearest valid port is assigned last.
  always_comb begin
    int         pos_v;
    logic [IdxW-1:0] sel_v;
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    for (int i = int'(NumPorts) - 1; i >= 0; i--) begin
      pos_v = int'(ptr_i) + i;
      if (pos_v >= int'(NumPorts)) begin
        pos_v = pos_v - int'(NumPorts);
      end else begin
        pos_v = pos_v;
      end
      sel_v = IdxW'(pos_v);
      if (valid_i[sel_v]) begin
        onehot_o        = '0;
        onehot_o[sel_v] = 1'b1;
        idx_o           = sel_v;
        any_o           = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing the eth_top TX stream port.
// Oversize frames are cut with an error-marked last beat and the remainder drained.
module eth_tx_arbiter
  import eth_top_pkg::*;
  import eth_tx_arb_pkg::*;
#(
  parameter int unsigned NumPorts = 4,
  parameter int unsigned MaxBeats = MAX_BEATS_DEFAULT,
  parameter int unsigned CntWidth = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               en_i,
  input  s_req_t [NumPorts-1:0]              req_i,
  output s_rsp_t [NumPorts-1:0]              rsp_o,
  output s_req_t                             mst_req_o,
  input  s_rsp_t                             mst_rsp_i,
  output logic   [NumPorts-1:0]              grant_o,
  output logic                               busy_o,
  output logic                               trunc_o,
  output logic   [NumPorts-1:0][CntWidth-1:0] frames_o
);

  localparam int unsigned IdxW = (NumPorts > 32'd1) ? $clog2(NumPorts) : 32'd1;
  localparam logic [CntWidth-1:0] LAST_CNT = CntWidth'(MaxBeats - 32'd1);
  localparam logic [IdxW-1:0]     LAST_IDX = IdxW'(NumPorts - 32'd1);

  arb_state_e          state_r, state_s;
  logic [IdxW-1:0]     ptr_r, ptr_s;
  logic [IdxW-1:0]     gidx_r, gidx_s;
  logic [NumPorts-1:0] grant_r, grant_s;
  logic [CntWidth-1:0] cnt_r, cnt_s;
  logic                busy_r;
  logic                frame_done_s;
  logic                force_s;
  logic                hs_s;
  logic [IdxW-1:0]     gidx_inc_s;
  s_req_t              sel_s;
  logic [NumPorts-1:0] valid_s;
  logic [NumPorts-1:0] pick_onehot_s;
  logic [IdxW-1:0]     pick_idx_s;
  logic                pick_any_s;

  // Collect the tvalid bits of all requesters for the picker.
  always_comb begin
    valid_s = '0;
    for (int k = 0; k < int'(NumPorts); k++) begin
      valid_s[k] = req_i[k].tvalid;
    end
  end

  eth_rr_pick #(
    .NumPorts (NumPorts),
    .IdxW     (IdxW)
  ) u_pick (
    .valid_i  (valid_s),
    .ptr_i    (ptr_r),
    .onehot_o (pick_onehot_s),
    .idx_o    (pick_idx_s),
    .any_o    (pick_any_s)
  );

  // Next-state, stream steering and truncation decode.
  always_comb begin
    state_s      = state_r;
    ptr_s        = ptr_r;
    gidx_s       = gidx_r;
    grant_s      = grant_r;
    cnt_s        = cnt_r;
    frame_done_s = 1'b0;
    trunc_o      = 1'b0;
    mst_req_o    = '0;
    rsp_o        = '0;
    sel_s        = req_i[gidx_r];
    force_s      = 1'b0;
    hs_s         = 1'b0;
    gidx_inc_s   = (gidx_r == LAST_IDX) ? '0 : (gidx_r + IdxW'(1));
    case (state_r)
      ST_IDLE: begin
        if (en_i && pick_any_s) begin
          state_s = ST_PASS;
          grant_s = pick_onehot_s;
          gidx_s  = pick_idx_s;
          cnt_s   = '0;
        end else begin
          grant_s = '0;
        end
      end
      ST_PASS: begin
        // A beat sitting in the last allowed slot without tlast gets cut here.
        force_s               = (cnt_r == LAST_CNT) && !sel_s.tlast;
        mst_req_o             = sel_s;
        mst_req_o.tlast       = sel_s.tlast | force_s;
        mst_req_o.tuser       = sel_s.tuser | force_s;
        rsp_o[gidx_r].tready  = mst_rsp_i.tready;
        hs_s                  = sel_s.tvalid & mst_rsp_i.tready;
        if (hs_s) begin
          cnt_s = cnt_r + CntWidth'(1);
          if (sel_s.tlast) begin
            state_s      = ST_IDLE;
            grant_s      = '0;
            ptr_s        = gidx_inc_s;
            frame_done_s = 1'b1;
          end else if (force_s) begin
            state_s      = ST_DRAIN;
            ptr_s        = gidx_inc_s;
            frame_done_s = 1'b1;
            trunc_o      = 1'b1;
          end else begin
            state_s = ST_PASS;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_DRAIN: begin
        rsp_o[gidx_r].tready = 1'b1;
        if (sel_s.tvalid && sel_s.tlast) begin
          state_s = ST_IDLE;
          grant_s = '0;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = '0;
      end
    endcase
  end

  // State, pointer, grant, beat counter and per-port frame statistics.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      ptr_r    <= '0;
      gidx_r   <= '0;
      grant_r  <= '0;
      cnt_r    <= '0;
      busy_r   <= 1'b0;
      frames_o <= '0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      gidx_r  <= gidx_s;
      grant_r <= grant_s;
      cnt_r   <= cnt_s;
      busy_r  <= (state_s != ST_IDLE);
      if (frame_done_s) begin
        frames_o[gidx_r] <= frames_o[gidx_r] + CntWidth'(1);
      end else begin
        frames_o <= frames_o;
      end
    end
  end

  assign grant_o = grant_r;
  assign busy_o  = busy_r;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter with MaxBeats = 4 and four requesters.
module tb_eth_tx_arbiter;
  import eth_top_pkg::*;

  localparam int N  = 4;
  localparam int MB = 4;
  localparam int CW = 16;

  logic clk_i = 1'b0;
  always #4 clk_i = ~clk_i;

  logic                  rst_i;
  logic                  en_i;
  s_req_t [N-1:0]        req_i;
  s_rsp_t [N-1:0]        rsp_o;
  s_req_t                mst_req_o;
  s_rsp_t                mst_rsp_i;
  logic   [N-1:0]        grant_o;
  logic                  busy_o;
  logic                  trunc_o;
  logic   [N-1:0][CW-1:0] frames_o;

  eth_tx_arbiter #(.NumPorts(N), .MaxBeats(MB), .CntWidth(CW)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .req_i     (req_i),
    .rsp_o     (rsp_o),
    .mst_req_o (mst_req_o),
    .mst_rsp_i (mst_rsp_i),
    .grant_o   (grant_o),
    .busy_o    (busy_o),
    .trunc_o   (trunc_o),
    .frames_o  (frames_o)
  );

  int total = 0;
  int bad   = 0;

  // source model: pend frames of flen beats each
  int   flen[N];
  int   pend[N];
  int   beat[N];
  int   fid[N];
  logic fuser[N];
  int   stall_pct;
  int   cyc;
  int   trunc_n;
  int   drained[N];

  // output-side log
  logic [63:0] lg_data[$];
  logic        lg_last[$];
  logic        lg_user[$];
  int          lg_port[$];
  int          lg_cyc[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit pend_any();
    for (int i = 0; i < N; i++) begin
      if (pend[i] > 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (pend[k] > 0) begin
        req_i[k].tvalid = 1'b1;
        req_i[k].tdata  = {8'(k), 24'h0, 16'(fid[k]), 16'(beat[k])};
        req_i[k].tlast  = (beat[k] == flen[k] - 1);
        req_i[k].tuser  = fuser[k] & (beat[k] == 1);
      end else begin
        req_i[k] = '0;
      end
    end
  endtask

  task automatic load(input int k, input int len, input logic usr);
    flen[k]  = len;
    pend[k]  = pend[k] + 1;
    beat[k]  = 0;
    fuser[k] = usr;
    drive();
  endtask

  task automatic clear_log();
    lg_data.delete(); lg_last.delete(); lg_user.delete();
    lg_port.delete(); lg_cyc.delete();
  endtask

  // One cycle: sample at negedge, advance sources after the posedge.
  task automatic step();
    logic [N-1:0] hs;
    @(negedge clk_i);
    if (mst_req_o.tvalid && mst_rsp_i.tready) begin
      lg_data.push_back(mst_req_o.tdata);
      lg_last.push_back(mst_req_o.tlast);
      lg_user.push_back(mst_req_o.tuser);
      lg_port.push_back(oh2i(grant_o));
      lg_cyc.push_back(cyc);
    end
    if (trunc_o) trunc_n++;
    for (int k = 0; k < N; k++) begin
      hs[k] = req_i[k].tvalid & rsp_o[k].tready;
      if (hs[k] && !mst_req_o.tvalid) drained[k]++;
    end
    @(posedge clk_i);
    #1;
    for (int k = 0; k < N; k++) begin
      if (hs[k]) begin
        beat[k]++;
        if (beat[k] == flen[k]) begin
          beat[k] = 0;
          fid[k]++;
          pend[k]--;
        end
      end
    end
    mst_rsp_i.tready = ($urandom_range(99) >= stall_pct);
    drive();
    cyc++;
  endtask

  task automatic run_idle(input int bound);
    int n = 0;
    while ((pend_any() || busy_o) && n < bound) begin
      step();
      n++;
    end
    check("timeout", 64'(n < bound), 64'(1));
  endtask

  int order[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  int tn;

  initial begin
    for (int k = 0; k < N; k++) begin
      flen[k] = 1; pend[k] = 0; beat[k] = 0; fid[k] = 0; fuser[k] = 1'b0; drained[k] = 0;
    end
    cyc = 0; trunc_n = 0; stall_pct = 0;
    rst_i = 1'b1; en_i = 1'b1; mst_rsp_i.tready = 1'b1;
    drive();

    // ---- reset state
    step(); step();
    check("rst_tvalid", 64'(mst_req_o.tvalid), 64'(0));
    check("rst_grant",  64'(grant_o), 64'(0));
    check("rst_busy",   64'(busy_o), 64'(0));
    check("rst_trunc",  64'(trunc_o), 64'(0));
    check("rst_frames", 64'(frames_o), 64'(0));
    check("rst_tready", 64'(rsp_o), 64'(0));
    rst_i = 1'b0;

    // ---- single port, 3 beats, random stalls
    clear_log();
    load(0, 3, 1'b0);
    check("sp_idle_tvalid", 64'(mst_req_o.tvalid), 64'(0));
    check("sp_idle_tready", 64'(rsp_o[0].tready), 64'(0));
    step();
    check("sp_grant", 64'(grant_o), 64'(4'b0001));
    check("sp_busy",  64'(busy_o), 64'(1));
    check("sp_first_valid", 64'(mst_req_o.tvalid), 64'(1));
    stall_pct = 40;
    run_idle(200);
    check("sp_beats", 64'(lg_data.size()), 64'(3));
    for (int i = 0; i < 3 && i < lg_data.size(); i++) begin
      check($sformatf("sp_data%0d", i), lg_data[i], {8'd0, 24'h0, 16'd0, 16'(i)});
      check($sformatf("sp_last%0d", i), 64'(lg_last[i]), 64'(i == 2));
    end
    check("sp_frames0", 64'(frames_o[0]), 64'(1));
    check("sp_grant_end", 64'(grant_o), 64'(0));

    // ---- round robin: all four ports, two 3-beat frames each, ptr starts at 1
    clear_log();
    stall_pct = 0;
    mst_rsp_i.tready = 1'b1;
    for (int k = 0; k < N; k++) load(k, 3, 1'b0);
    for (int k = 0; k < N; k++) pend[k] = 2;
    run_idle(200);
    check("rr_beats", 64'(lg_data.size()), 64'(24));
    for (int i = 0; i < 24 && i < lg_data.size(); i++) begin
      check($sformatf("rr_port%0d", i), 64'(lg_port[i]), 64'(order[i / 3]));
      check($sformatf("rr_src%0d", i), 64'(lg_data[i][63:56]), 64'(order[i / 3]));
      check($sformatf("rr_beat%0d", i), 64'(lg_data[i][15:0]), 64'(i % 3));
      check($sformatf("rr_last%0d", i), 64'(lg_last[i]), 64'(i % 3 == 2));
      if (i > 0) check($sformatf("rr_gap%0d", i), 64'(lg_cyc[i] - lg_cyc[i-1]),
                       64'((i % 3 == 0) ? 2 : 1));
    end
    check("rr_frames", 64'(frames_o), {16'd2, 16'd2, 16'd2, 16'd3});

    // ---- truncation: port 2 sends 10 beats, MaxBeats is 4
    clear_log();
    stall_pct = 30;
    load(2, 10, 1'b0);
    step();
    check("tr_grant", 64'(grant_o), 64'(4'b0100));
    run_idle(300);
    check("tr_beats", 64'(lg_data.size()), 64'(4));
    for (int i = 0; i < 4 && i < lg_data.size(); i++) begin
      check($sformatf("tr_data%0d", i), 64'(lg_data[i][15:0]), 64'(i));
      check($sformatf("tr_last%0d", i), 64'(lg_last[i]), 64'(i == 3));
      check($sformatf("tr_user%0d", i), 64'(lg_user[i]), 64'(i == 3));
    end
    check("tr_pulses", 64'(trunc_n), 64'(1));
    check("tr_drained", 64'(drained[2]), 64'(6));
    check("tr_frames2", 64'(frames_o[2]), 64'(3));
    clear_log();
    load(1, 2, 1'b0);
    load(3, 2, 1'b0);
    run_idle(200);
    check("tr_next_port", 64'(lg_port.size() > 0 ? lg_port[0] : -1), 64'(3));
    check("tr_then_port", 64'(lg_port.size() > 2 ? lg_port[2] : -1), 64'(1));

    // ---- exact length: 4 beats with tlast on beat 4
    clear_log();
    tn = trunc_n;
    load(0, 4, 1'b1);
    run_idle(200);
    check("ex_beats", 64'(lg_data.size()), 64'(4));
    check("ex_last3", 64'(lg_last.size() > 3 ? lg_last[3] : 1'bx), 64'(1));
    check("ex_user3", 64'(lg_user.size() > 3 ? lg_user[3] : 1'bx), 64'(0));
    check("ex_user1", 64'(lg_user.size() > 1 ? lg_user[1] : 1'bx), 64'(1));
    check("ex_no_trunc", 64'(trunc_n - tn), 64'(0));
    check("ex_frames0", 64'(frames_o[0]), 64'(4));

    // ---- enable gating: drop en_i mid-frame of port 1, port 2 waits
    clear_log();
    stall_pct = 0;
    mst_rsp_i.tready = 1'b1;
    load(1, 4, 1'b0);
    load(2, 2, 1'b0);
    step(); step();
    check("en_mid_busy", 64'(busy_o), 64'(1));
    en_i = 1'b0;
    repeat (12) step();
    check("en_beats", 64'(lg_data.size()), 64'(4));
    check("en_port", 64'(lg_port.size() > 3 ? lg_port[3] : -1), 64'(1));
    check("en_idle_busy", 64'(busy_o), 64'(0));
    check("en_idle_grant", 64'(grant_o), 64'(0));
    check("en_pend2", 64'(pend[2]), 64'(1));
    check("en_frames1", 64'(frames_o[1]), 64'(4));
    en_i = 1'b1;
    run_idle(200);
    check("en_resume", 64'(lg_port.size() > 5 ? lg_port[5] : -1), 64'(2));
    check("en_frames2", 64'(frames_o[2]), 64'(4));

    // ---- reset mid-frame of port 3 while port 1 also waits
    clear_log();
    load(3, 4, 1'b0);
    load(1, 2, 1'b0);
    tn = 0;
    while (beat[3] != 2 && tn < 20) begin
      step();
      tn++;
    end
    check("mr_reach_beat3", 64'(tn < 20), 64'(1));
    check("mr_grant_pre", 64'(grant_o), 64'(4'b1000));
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    beat[3] = 0;
    drive();
    check("mr_tvalid", 64'(mst_req_o.tvalid), 64'(0));
    check("mr_grant",  64'(grant_o), 64'(0));
    check("mr_busy",   64'(busy_o), 64'(0));
    check("mr_frames", 64'(frames_o), 64'(0));
    step();
    check("mr_lowest", 64'(grant_o), 64'(4'b0010));
    run_idle(200);
    check("mr_frames1", 64'(frames_o[1]), 64'(1));
    check("mr_frames3", 64'(frames_o[3]), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Frame-granular round-robin arbiter that shares the single `eth_top` TX AXI-Stream port (`tx_axis_req_i`/`tx_axis_rsp_o`) between `NumPorts` requesters. Grants are held from a frame's first beat through its `tlast` handshake, so frames never interleave on the wire. Oversize frames are truncated: the arbiter ends the frame on the MAC side with an error-marked last beat, then silently drains the rest from the source. The block sits between the on-chip stream sources and `eth_top`, in the `eth_top` clock domain.

## Interface
- `NumPorts`, default 4: number of requesters, 2..16.
- `MaxBeats`, default 190: maximum beats per frame, 64-bit beats (190 × 8 B ≥ 1518 B). Range 2..65535.
- `CntWidth`, default 16: width of the beat counter and of the statistics counters.
- `clk_i`, in, 1: 125 MHz system clock, the same clock as `eth_top` `clk_i`.
- `rst_i`, in, 1: synchronous, active-high reset.
- `en_i`, in, 1: allows new grants. Deasserting it never cuts a frame already in progress.
- `req_i`, in, `NumPorts` × `eth_top_pkg::s_req_t`: requester streams (`tdata` 64, `tlast`, `tuser` 1, `tvalid`).
- `rsp_o`, out, `NumPorts` × `eth_top_pkg::s_rsp_t`: `tready` back to each requester.
- `mst_req_o`, out, `eth_top_pkg::s_req_t`: stream to `eth_top` `tx_axis_req_i`.
- `mst_rsp_i`, in, `eth_top_pkg::s_rsp_t`: `tready` from `eth_top`.
- `grant_o`, out, `NumPorts`: one-hot current grant; all zero in IDLE.
- `busy_o`, out, 1: high in PASS or DRAIN.
- `trunc_o`, out, 1: one-cycle pulse on the forced-last beat of a truncated frame.
- `frames_o`, out, `NumPorts` × `CntWidth`: completed frames per port. Wraps modulo 2^`CntWidth`; truncated frames are counted.

## Operation
- **FSM states:** IDLE, PASS, DRAIN.
- **IDLE:**
  - `mst_req_o.tvalid` = 0 and every `tready` = 0.
  - If `en_i` is high and any `req_i[k].tvalid` is high, pick the first valid port scanning from `ptr` upward, wrapping at `NumPorts`.
  - Register the winner into `grant` and go to PASS. The beat counter `cnt` is cleared.
- **PASS:**
  - The granted port drives `mst_req_o` combinationally (`tdata`, `tlast`, `tuser`, `tvalid`).
  - `rsp_o[g].tready` = `mst_rsp_i.tready`; all other `tready` = 0.
  - Each output handshake increments `cnt`.
  - **Handshake with `tlast` = 1:** go to IDLE, set `ptr` = (g+1) mod `NumPorts`, increment `frames_o[g]`.
  - **Handshake with `tlast` = 0 while `cnt` == `MaxBeats`−1 (truncation):**
    - On that beat, output `tlast` and `tuser` are forced to 1.
    - `trunc_o` pulses and `frames_o[g]` increments.
    - `ptr` = g+1; go to DRAIN.
  - A source beat that carries `tlast` exactly at `cnt` == `MaxBeats`−1 is a legal frame. It is not truncated.
- **DRAIN:**
  - `mst_req_o.tvalid` = 0.
  - `rsp_o[g].tready` = 1; source beats are discarded.
  - On a source handshake with `tlast`, go to IDLE.
- **Protocol rules:**
  - The source's `tuser` passes through unmodified except on a forced-last beat.
  - `tdata` is not inspected.
  - Output `tvalid` never drops without a handshake while in PASS, provided the source obeys AXI-S.
- **Reset:** state = IDLE, `ptr` = 0, `grant` = 0, `cnt` = 0, all `frames_o` = 0, and `busy_o`/`trunc_o`/all `tready`/`mst_req_o.tvalid` = 0. A reset during PASS or DRAIN abandons the frame; `eth_top` sees `tvalid` fall without `tlast`, which is accepted system behaviour.

## Timing
- **Arbitration latency:** one cycle. A source `tvalid` sampled high in IDLE at edge n makes first-beat output valid after edge n+1.
- **Throughput:** one beat per cycle inside a frame. There is one IDLE bubble cycle between consecutive frames, and between the end of DRAIN and the next frame.
- **Combinational paths:** `req_i` → `mst_req_o` and `mst_rsp_i` → `rsp_o`. There is no register stage in the data path.
- **Simultaneous events:** a new requester asserting during PASS waits; `en_i` falling in the same cycle as the IDLE pick blocks the grant.

## Structure
- Reuse `eth_top_pkg::s_req_t`/`s_rsp_t`.
- Add `eth_tx_arb_pkg` with the FSM enum `arb_state_e` and the default `MaxBeats` constant.
- Sub-module `eth_rr_pick`: combinational round-robin picker (`valid` vector, `ptr` → one-hot plus index, `any`).

## Test plan
- **Single port:** port 0 sends 8 beats (`tlast` on beat 8) with random tready stalls → 8 identical beats at `eth_top`; `frames_o[0]` = 1; `grant_o` = 0001 during the frame.
- **Round-robin fairness:** all 4 ports hold 8-beat frames continuously → grant order 0,1,2,3,0 with no interleave; 1 idle cycle between frames.
- **Truncation:** `MaxBeats` = 4, port 2 sends 10 beats → 4 output beats, the 4th with `tlast` = 1 and `tuser` = 1; `trunc_o` pulses once; the 6 remaining beats are drained; next grant goes to port 3.
- **Exact length:** `MaxBeats` = 4, a 4-beat frame with `tlast` on beat 4 → no `trunc_o`, `tuser` unchanged.
- **Enable gating:** `en_i` dropped mid-frame → the frame completes, then no further grants until `en_i` returns.
- **Reset mid-frame:** assert `rst_i` at beat 3 → the next cycle has `tvalid` = 0, `ptr` = 0, counters 0; the next frame is granted to the lowest valid port.
